iter_mult18: RTL
================

// Module: iter_mult18
// PURPOSE
//  Iterative shift-add unsigned multiplier that answers the start/done handshake issued by the
//  logistic-map evaluator (x*(1-x), then mu*term). One operand bit per clock; no DSP block needed.
//  Sits between the evaluator control and its fixed-point datapath; one instance per evaluator.
// PARAMETERS
//  WIDTH  18  operand width in bits; result is 2*WIDTH bits.
// PORTS
//  CLK     in   1        single clock; all state updates on posedge.
//  RST     in   1        asynchronous, active-low reset (RST==0 resets immediately).
//  start   in   1        request; sampled on posedge CLK.
//  dataa   in   WIDTH    multiplicand, unsigned; sampled only on the accept edge.
//  datab   in   WIDTH    multiplier, unsigned; sampled only on the accept edge.
//  busy    out  1        high while in RUN.
//  done    out  1        high in DONE; result valid and stable while done==1.
//  result  out  2*WIDTH  unsigned product dataa*datab.
// BEHAVIOUR
//  - Reset (RST==0, async): state=IDLE, busy=0, done=0, result=0, internal regs=0.
//  - States: IDLE, RUN, DONE. DONE holds until next accepted start.
//  - Accept edge: start==1 in IDLE or DONE -> a_sh<={WIDTH'b0,dataa}, b_sh<=datab, acc<=0,
//    cnt<=0, done<=0, busy<=1, state<=RUN. start in RUN is ignored (no restart, no error).
//  - RUN edge: if b_sh[0] acc<=acc+a_sh; a_sh<=a_sh<<1; b_sh<=b_sh>>1; cnt<=cnt+1.
//    On the edge where cnt==WIDTH-1: result<=final acc, done<=1, busy<=0, state<=DONE.
//  - Latency: accept edge k -> done visible after edge k+WIDTH (18 cycles at default).
//  - Arithmetic: acc and a_sh are 2*WIDTH bits; never overflow; no rounding or truncation here
//    (caller selects Q-format slice, e.g. result[33:16]).
//  - done rises exactly once per accepted start; result register is written only on that edge,
//    so result keeps the previous product during RUN.
//  - Back-to-back: start held high in DONE restarts on the next edge; done drops on that edge.
//  - Reset mid-RUN: aborts immediately to reset values; no done pulse is produced.
//  - Operand change on dataa/datab after the accept edge has no effect on the running product.
// CONFIGURATION
//  ITER_MULT_EARLY_TERM_EN defined: in RUN, if the shifted multiplier (b_sh>>1) is zero after
//   the current step, finish on that edge (result<=acc+addend, go DONE). Latency =
//   max(1, index of highest set bit of datab + 1); datab==0 finishes after 1 RUN edge, result=0.
//  Not defined: fixed latency of WIDTH cycles for every operand pair (deterministic timing).
// STRUCTURE
//  - Shared package chaos_pkg: WIDTH default (18), state encoding localparams
//    ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, counter width CNT_W=$clog2(WIDTH).
//  - No sub-module: FSM, counter and shift-add datapath in this file.
// TESTING
//  1. Reset release, idle 5 cycles -> busy=0, done=0, result=0.
//  2. dataa=3, datab=5, start 1 cycle -> busy for 18 cycles, done after edge k+18, result=15.
//  3. dataa=datab=18'h3FFFF -> result=36'hF_FFF8_0001; ext-off latency 18.
//  4. Q16: dataa=18'h10000, datab=18'h08000 -> result=36'h0_8000_0000; result[33:16]=18'h08000.
//  5. start re-pulsed at RUN cycle 7, operands changed -> ignored, original product at cycle 18;
//     RST low at RUN cycle 9 of next op -> immediate reset values, no done.
//  6. With ITER_MULT_EARLY_TERM_EN: datab=1 -> done after 1 edge, result=dataa; datab=0 -> 1
//     edge, result=0; datab=18'h20000 -> 18 edges. Without it: all three take 18 edges.

Source files
------------

// File: rtl/chaos_pkg.sv
// Shared definitions for the logistic-map evaluator: operand width default and multiplier FSM encoding.
package chaos_pkg;

  localparam int WIDTH = 18;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } mult_state_e;

endpackage

// File: rtl/iter_mult18.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock, start/done handshake.
// Optional ITER_MULT_EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module iter_mult18 #(
  parameter int WIDTH = chaos_pkg::WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);
  import chaos_pkg::*;

  localparam int CntW = $clog2(WIDTH);

  mult_state_e          state_q, state_d;
  logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_sh_q, b_sh_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   sum;
  logic [WIDTH-1:0]     bNext;
  logic                 lastStep;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;

    addend   = b_sh_q[0] ? a_sh_q : '0;
    sum      = acc_q + addend;
    bNext    = b_sh_q >> 1;
`ifdef ITER_MULT_EARLY_TERM_EN
    lastStep = (cnt_q == CntW'(WIDTH - 1)) || (bNext == '0);
`else
    lastStep = (cnt_q == CntW'(WIDTH - 1));
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = {{WIDTH{1'b0}}, dataa};
          b_sh_d  = datab;
          acc_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: a running product cannot be restarted
        acc_d  = sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = bNext;
        cnt_d  = cnt_q + CntW'(1);
        if (lastStep) begin
          result_d = sum;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
